// File: rtl/opcode_issuer_if.sv
// Byte-stream intake and accumulator command bundle for opcode_issuer.
// The issuer side is the master: it consumes bytes and drives the accumulator command.
interface opcode_issuer_if;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic [23:0] opcode;
   logic [7:0]  acc_data_in;
   logic        op_rdy;
   logic        acc_en;
   logic        bad_op;
   logic [7:0]  issue_cnt;

   modport master (
      input  in_valid, in_byte,
      output in_ready, opcode, acc_data_in, op_rdy, acc_en, bad_op, issue_cnt
   );

   modport slave (
      output in_valid, in_byte,
      input  in_ready, opcode, acc_data_in, op_rdy, acc_en, bad_op, issue_cnt
   );
endinterface

// File: rtl/opcode_issuer.sv
// Byte-serial instruction front end: gathers a 3-byte opcode (MSB first) plus an optional
// operand, then issues it to the accumulator as a single-cycle acc_en/op_rdy strobe.
module opcode_issuer #(
   parameter logic [23:0] LDA = 24'h888800,
   parameter logic [23:0] INC = 24'h888801,
   parameter logic [23:0] DEC = 24'h888802
) (
   input logic            clk,
   input logic            iss_rst,
   opcode_issuer_if.master bus
);

   typedef enum logic [2:0] {
      S_B0    = 3'd0,
      S_B1    = 3'd1,
      S_B2    = 3'd2,
      S_OPND  = 3'd3,
      S_ISSUE = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      K_LOAD  = 2'd0,
      K_UNARY = 2'd1,
      K_BAD   = 2'd2
   } kind_t;

   state_t      state_r;
   logic [15:0] shadow_r;
   logic [23:0] opcode_r;
   logic [7:0]  acc_data_r;
   logic        op_rdy_r;
   logic        acc_en_r;
   logic        bad_op_r;
   logic [7:0]  issue_cnt_r;
   logic        in_ready_r;
   logic        accept_s;
   logic [23:0] code_s;
   kind_t       kind_s;

   function automatic kind_t decode_op(input logic [23:0] code);
      kind_t k;
      if (code == LDA) begin
         k = K_LOAD;
      end else if ((code == INC) || (code == DEC)) begin
         k = K_UNARY;
      end else begin
         k = K_BAD;
      end
      return k;
   endfunction

   // Handshake qualification and decode of the candidate opcode in S_B2.
   always_comb begin
      accept_s = 1'b0;
      code_s   = 24'h000000;
      kind_s   = K_BAD;
      accept_s = bus.in_valid && in_ready_r;
      code_s   = {shadow_r, bus.in_byte};
      kind_s   = decode_op(code_s);
   end

   // Collection FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (iss_rst) begin
         state_r     <= S_B0;
         shadow_r    <= 16'h0000;
         opcode_r    <= 24'h000000;
         acc_data_r  <= 8'h00;
         op_rdy_r    <= 1'b0;
         acc_en_r    <= 1'b0;
         bad_op_r    <= 1'b0;
         issue_cnt_r <= 8'h00;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            S_B0: begin
               if (accept_s) begin
                  shadow_r[15:8] <= bus.in_byte;
                  state_r        <= S_B1;
               end
            end
            S_B1: begin
               if (accept_s) begin
                  shadow_r[7:0] <= bus.in_byte;
                  state_r       <= S_B2;
               end
            end
            S_B2: begin
               if (accept_s) begin
                  case (kind_s)
                     K_LOAD: begin
                        state_r <= S_OPND;
                     end
                     K_UNARY: begin
                        state_r    <= S_ISSUE;
                        opcode_r   <= code_s;
                        acc_data_r <= 8'h00;
                        op_rdy_r   <= 1'b1;
                        acc_en_r   <= 1'b1;
                        in_ready_r <= 1'b0;
                     end
                     default: begin
                        // Unknown code: drop it, keep the last issued command intact.
                        state_r    <= S_ERR;
                        bad_op_r   <= 1'b1;
                        in_ready_r <= 1'b0;
                     end
                  endcase
               end
            end
            S_OPND: begin
               if (accept_s) begin
                  state_r    <= S_ISSUE;
                  opcode_r   <= LDA;
                  acc_data_r <= bus.in_byte;
                  op_rdy_r   <= 1'b1;
                  acc_en_r   <= 1'b1;
                  in_ready_r <= 1'b0;
               end
            end
            S_ISSUE: begin
               state_r     <= S_B0;
               op_rdy_r    <= 1'b0;
               acc_en_r    <= 1'b0;
               issue_cnt_r <= issue_cnt_r + 8'd1;
               in_ready_r  <= 1'b1;
            end
            S_ERR: begin
               state_r    <= S_B0;
               bad_op_r   <= 1'b0;
               in_ready_r <= 1'b1;
            end
            default: begin
               state_r    <= S_B0;
               op_rdy_r   <= 1'b0;
               acc_en_r   <= 1'b0;
               bad_op_r   <= 1'b0;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.opcode      = opcode_r;
   assign bus.acc_data_in = acc_data_r;
   assign bus.op_rdy      = op_rdy_r;
   assign bus.acc_en      = acc_en_r;
   assign bus.bad_op      = bad_op_r;
   assign bus.issue_cnt   = issue_cnt_r;

endmodule
